load_store_unit: RTL and testbench

- Sits between the execute stage and the word-addressed data memory (32-bit words, combinational read, synchronous write on clk).
- Converts RISC-V loads and stores (LB/LH/LW/LBU/LHU, SB/SH/SW) into word accesses.
- Performs read-modify-write for sub-word stores, and sign/zero-extension for loads.
- Flags misaligned, illegal-funct3 and out-of-range accesses without touching memory.

---
 rtl/load_store_unit_if.sv | 29 ++
 rtl/load_store_unit.sv | 141 ++++++++++++++
 tb/tb_load_store_unit.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Request/response handshake and data-memory bus of the load/store unit.
// slave = the unit itself; master = execute stage plus data memory.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  // Handshake: a request transfers on a rising edge where req_valid && req_ready;
  // upstream holds the request stable until then. resp_valid is a one-cycle pulse.
  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/load_store_unit.sv
// RISC-V load/store unit: turns byte/half/word accesses into word accesses on a
// word-addressed memory, with read-modify-write for sub-word stores.
module load_store_unit #(
  parameter int MEM_BYTES   = 1024,
  parameter int RANGE_CHECK = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  load_store_unit_if.slave   bus,
  output logic [2:0]         dbg_state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    MERGE = 3'd2,
    WRITE = 3'd3,
    ERR   = 3'd4
  } state_t;

  state_t      state;
  logic [2:0]  lat_f3;
  logic [31:0] lat_addr;
  logic [15:0] lat_wdata;
  logic        resp_valid_q;
  logic [31:0] resp_rdata_q;
  logic        resp_err_q;
  logic [31:0] mem_wdata_q;

  function automatic logic req_bad(input logic we, input logic [2:0] f3,
                                   input logic [31:0] addr);
    logic bad;
    bad = 1'b0;
    if (we) begin
      if (f3 != 3'b000 && f3 != 3'b001 && f3 != 3'b010) bad = 1'b1;
    end else begin
      if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) bad = 1'b1;
    end
    if (f3[1:0] == 2'b01 && addr[0]) bad = 1'b1;
    if (f3[1:0] == 2'b10 && addr[1:0] != 2'b00) bad = 1'b1;
    if (RANGE_CHECK != 0 && addr >= 32'(MEM_BYTES)) bad = 1'b1;
    return bad;
  endfunction

  // Little-endian lane select followed by sign or zero extension.
  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = w[{off, 3'b000} +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b100:  r = {24'd0, b};
      3'b101:  r = {16'd0, h};
      default: r = w;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] merge_word(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] w, input logic [15:0] wd);
    logic [31:0] r;
    r = w;
    if (f3[1:0] == 2'b00) r[{off, 3'b000} +: 8] = wd[7:0];
    else if (off[1])      r[31:16] = wd;
    else                  r[15:0]  = wd;
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      lat_f3       <= 3'd0;
      lat_addr     <= 32'd0;
      lat_wdata    <= 16'd0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'd0;
      resp_err_q   <= 1'b0;
      mem_wdata_q  <= 32'd0;
    end else begin
      resp_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            lat_f3    <= bus.req_funct3;
            lat_addr  <= bus.req_addr;
            lat_wdata <= bus.req_wdata[15:0];
            if (req_bad(bus.req_we, bus.req_funct3, bus.req_addr)) begin
              state <= ERR;
            end else if (!bus.req_we) begin
              state <= LOAD;
            end else if (bus.req_funct3 == 3'b010) begin
              // Full-word store needs no read, so its data goes straight out.
              mem_wdata_q <= bus.req_wdata;
              state       <= WRITE;
            end else begin
              state <= MERGE;
            end
          end
        end
        LOAD: begin
          resp_valid_q <= 1'b1;
          resp_rdata_q <= load_ext(lat_f3, lat_addr[1:0], bus.mem_rdata);
          resp_err_q   <= 1'b0;
          state        <= IDLE;
        end
        MERGE: begin
          mem_wdata_q <= merge_word(lat_f3, lat_addr[1:0], bus.mem_rdata, lat_wdata);
          state       <= WRITE;
        end
        WRITE: begin
          resp_valid_q <= 1'b1;
          resp_rdata_q <= 32'd0;
          resp_err_q   <= 1'b0;
          state        <= IDLE;
        end
        ERR: begin
          resp_valid_q <= 1'b1;
          resp_rdata_q <= 32'd0;
          resp_err_q   <= 1'b1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Decoded from state so an asynchronous reset drops the write strobe at once.
  assign bus.mem_write  = (state == WRITE);
  assign bus.req_ready  = (state == IDLE);
  assign bus.mem_addr   = (state == IDLE) ? 32'd0 : {lat_addr[31:2], 2'b00};
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;
  assign dbg_state      = state;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: driver tasks queue expected responses and
// writes; a negedge monitor pops and checks them against what the unit presents.
module tb_load_store_unit;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] dbg_state;

  load_store_unit_if bus();

  load_store_unit #(.MEM_BYTES(1024), .RANGE_CHECK(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- memory model ----------------
  logic [31:0] mem [0:255];
  logic        poke_en = 1'b0;
  logic [7:0]  poke_idx = 8'd0;
  logic [31:0] poke_data = 32'd0;

  always @(posedge clk) begin
    if (bus.mem_write) mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
    else if (poke_en)  mem[poke_idx] <= poke_data;
  end
  assign bus.mem_rdata = mem[bus.mem_addr[9:2]];

  // ---------------- scoreboard ----------------
  int tests = 0;
  int fails = 0;
  logic [64:0] exp_q[$];   // {err, rdata, due cycle}
  logic [95:0] wr_q[$];    // {word addr, data, due cycle}

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [64:0] e;
    logic [95:0] w;
    if (rst_n && bus.resp_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_resp", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("resp_err",   {31'd0, bus.resp_err}, {31'd0, e[64]});
        chk("resp_rdata", bus.resp_rdata, e[63:32]);
        chk("resp_cycle", cyc, e[31:0]);
      end
    end
    if (bus.mem_write) begin
      if (wr_q.size() == 0) begin
        chk("unexpected_write", bus.mem_addr, 32'hFFFF_FFFF);
      end else begin
        w = wr_q.pop_front();
        chk("wr_addr",  bus.mem_addr, w[95:64]);
        chk("wr_data",  bus.mem_wdata, w[63:32]);
        chk("wr_cycle", cyc, w[31:0]);
      end
    end
  end

  // ---------------- driver tasks (entered just after a negedge) ----------------
  task automatic poke(input logic [7:0] idx, input logic [31:0] data);
    poke_idx  = idx;
    poke_data = data;
    poke_en   = 1'b1;
    @(negedge clk);
    poke_en   = 1'b0;
  endtask

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic exp_err,
                       input logic [31:0] exp_rdata, input int resp_lat,
                       input logic do_wr, input logic [31:0] wr_data, output int acc_edge);
    int n;
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    n = 0;
    while (!bus.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
      bus.req_valid = 1'b0;
      acc_edge = -1;
      return;
    end
    acc_edge = cyc + 1;
    exp_q.push_back({exp_err, exp_rdata, 32'(acc_edge + resp_lat)});
    if (do_wr) wr_q.push_back({addr & 32'hFFFF_FFFC, wr_data, 32'(acc_edge + resp_lat - 1)});
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    chk("busy_ready", {31'd0, bus.req_ready}, 32'd0);
  endtask

  task automatic ld(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] exp);
    int a;
    issue(1'b0, f3, addr, 32'd0, 1'b0, exp, 1, 1'b0, 32'd0, a);
  endtask

  task automatic st(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                    input logic [31:0] word);
    int a;
    issue(1'b1, f3, addr, wd, 1'b0, 32'd0, (f3 == 3'b010) ? 1 : 2, 1'b1, word, a);
  endtask

  task automatic bad(input logic we, input logic [2:0] f3, input logic [31:0] addr);
    int a;
    issue(we, f3, addr, 32'h1234_5678, 1'b1, 32'd0, 1, 1'b0, 32'd0, a);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || wr_q.size() != 0) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("drain", exp_q.size() + wr_q.size(), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int a1;
    int a2;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'd0;
    bus.req_addr   = 32'd0;
    bus.req_wdata  = 32'd0;

    #1;
    chk("rst_ready",     {31'd0, bus.req_ready},  32'd1);
    chk("rst_resp_valid",{31'd0, bus.resp_valid}, 32'd0);
    chk("rst_rdata",     bus.resp_rdata,          32'd0);
    chk("rst_err",       {31'd0, bus.resp_err},   32'd0);
    chk("rst_mem_write", {31'd0, bus.mem_write},  32'd0);
    chk("rst_mem_addr",  bus.mem_addr,            32'd0);
    chk("rst_mem_wdata", bus.mem_wdata,           32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    poke(8'd4, 32'h8899_AABB);
    poke(8'd8, 32'h1122_3344);

    // loads: lane select and extension
    ld(3'b000, 32'h13, 32'hFFFF_FF88);
    ld(3'b100, 32'h13, 32'h0000_0088);
    ld(3'b000, 32'h10, 32'hFFFF_FFBB);
    ld(3'b100, 32'h11, 32'h0000_00AA);
    ld(3'b001, 32'h12, 32'hFFFF_8899);
    ld(3'b101, 32'h10, 32'h0000_AABB);
    ld(3'b010, 32'h10, 32'h8899_AABB);

    // sub-word stores
    st(3'b000, 32'h21, 32'h0000_00EE, 32'h1122_EE44);
    ld(3'b010, 32'h20, 32'h1122_EE44);
    drain();
    poke(8'd8, 32'h1122_3344);
    st(3'b001, 32'h22, 32'h0000_CAFE, 32'hCAFE_3344);
    ld(3'b001, 32'h22, 32'hFFFF_CAFE);
    ld(3'b101, 32'h22, 32'h0000_CAFE);
    st(3'b000, 32'h23, 32'hFFFF_FF77, 32'h77FE_3344);
    ld(3'b100, 32'h23, 32'h0000_0077);

    // errors: no write may appear
    bad(1'b0, 3'b010, 32'h06);
    bad(1'b1, 3'b001, 32'h03);
    bad(1'b0, 3'b011, 32'h04);
    bad(1'b1, 3'b010, 32'h400);
    bad(1'b1, 3'b100, 32'h00);
    bad(1'b0, 3'b110, 32'h00);
    bad(1'b0, 3'b001, 32'h11);
    ld(3'b010, 32'h3FC, 32'h0000_0000 | mem[255]);

    // back-to-back: LW accepted in the cycle the SW response is visible
    drain();
    issue(1'b1, 3'b010, 32'h0, 32'hDEAD_BEEF, 1'b0, 32'd0, 1, 1'b1, 32'hDEAD_BEEF, a1);
    issue(1'b0, 3'b010, 32'h0, 32'd0, 1'b0, 32'hDEAD_BEEF, 1, 1'b0, 32'd0, a2);
    chk("b2b_accept_gap", a2 - a1, 32'd2);
    drain();

    // reset during MERGE of an SB
    poke(8'd8, 32'h1122_3344);
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'h20;
    bus.req_wdata  = 32'h0000_0055;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    chk("merge_state", {29'd0, dbg_state}, 32'd2);
    #1 rst_n = 1'b0;
    #1;
    chk("mr_mem_write", {31'd0, bus.mem_write},  32'd0);
    chk("mr_ready",     {31'd0, bus.req_ready},  32'd1);
    chk("mr_resp_valid",{31'd0, bus.resp_valid}, 32'd0);
    chk("mr_rdata",     bus.resp_rdata,          32'd0);
    chk("mr_mem_addr",  bus.mem_addr,            32'd0);
    chk("mr_mem_wdata", bus.mem_wdata,           32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("mr_mem_kept", mem[8], 32'h1122_3344);
    ld(3'b010, 32'h20, 32'h1122_3344);
    st(3'b000, 32'h20, 32'h0000_0055, 32'h1122_3355);
    drain();
    chk("post_rst_store", mem[8], 32'h1122_3355);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
